// File: rtl/down_timer.sv
// down_timer: loadable modulo-M down-counter/timer with one-shot and auto-reload modes.
// Counterpart of the up-counting modulo-M counter: bo mirrors co at the bottom of the range.
module down_timer #(
  parameter int unsigned M = 32,
  localparam int unsigned W = $clog2(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         stop,
  input  logic         auto_reload,
  output logic [W-1:0] cnt,
  output logic         bo,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] MAX_CNT = W'(M - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] reload_q, reload_d;
  logic [W-1:0] load_sat;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         tick;

  // Clamp the requested start value into the legal range 0..M-1.
  always_comb begin
    load_sat = load_val;
    if (32'(load_val) >= M) begin
      load_sat = MAX_CNT;
    end
  end

  // Terminal tick: an enabled count step while sitting at zero.
  assign tick = (state_q == RUN) && en && (cnt_q == '0);

  // Next-state logic; stop outranks load, load outranks counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load) begin
      state_d  = RUN;
      cnt_d    = load_sat;
      reload_d = load_sat;
    end else if (state_q == RUN && en) begin
      if (cnt_q == '0) begin
        done_d = 1'b1;
        if (auto_reload) begin
          cnt_d = reload_q;
        end else begin
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end

    busy_d = (state_d == RUN);
  end

  // State and output registers; reset applies immediately, even mid-count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= MAX_CNT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign bo   = tick;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: a period-based reference model compared every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_down_timer;

  localparam int unsigned M    = 32;
  localparam int unsigned W    = $clog2(M);
  localparam int          LOGN = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         stop = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] cnt;
  logic         bo;
  logic         busy;
  logic         done;

  down_timer #(.M(M)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .stop        (stop),
    .auto_reload (auto_reload),
    .cnt         (cnt),
    .bo          (bo),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a run is described by its start value n and the number of
  // enabled ticks k taken since the load; the count is n - (k mod (n+1)).
  bit m_run  = 1'b0;
  int m_n    = 0;
  int m_k    = 0;
  bit m_done = 1'b0;
  logic prev_done = 1'b0;

  logic [W-1:0] log_cnt  [LOGN];
  logic         log_bo   [LOGN];
  logic         log_busy [LOGN];
  logic         log_done [LOGN];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic int model_cnt();
    return m_run ? (m_n - (m_k % (m_n + 1))) : 0;
  endfunction

  // Compare DUT outputs with the model and invariants for the current cycle.
  task automatic check_cycle();
    int ec;
    int eb;
    ec = model_cnt();
    eb = (m_run && en && ec == 0) ? 1 : 0;
    chk("cnt", 32'(cnt), ec);
    chk("bo", 32'(bo), eb);
    chk("busy", 32'(busy), m_run ? 1 : 0);
    chk("done", 32'(done), m_done ? 1 : 0);
    chk("inv_bo_cnt0", (bo && cnt != '0) ? 32'd1 : 32'd0, 0);
    chk("inv_cnt_lt_m", (32'(cnt) < M) ? 32'd1 : 32'd0, 1);
    chk("done_consec", (prev_done && done && m_n != 0) ? 32'd1 : 32'd0, 0);
    prev_done = done;
  endtask

  // Advance the model across a rising edge with the inputs currently applied.
  task automatic model_edge();
    int  n;
    bit  term;
    if (rst) begin
      m_run = 1'b0; m_k = 0; m_done = 1'b0;
      return;
    end
    term = m_run && en && (model_cnt() == 0);
    if (stop) begin
      m_run = 1'b0; m_done = 1'b0;
    end else if (load) begin
      n = int'(load_val);
      if (n > int'(M) - 1) n = int'(M) - 1;
      m_run = 1'b1; m_n = n; m_k = 0; m_done = 1'b0;
    end else begin
      m_done = term;
      if (m_run && en) begin
        if (term && !auto_reload) m_run = 1'b0;
        else m_k++;
      end
    end
  endtask

  // One clock cycle: apply inputs, sample and check at negedge, step model at posedge.
  task automatic step(input bit l, input bit st, input bit e, input bit ar, input int lv);
    load = l; stop = st; en = e; auto_reload = ar; load_val = W'(lv);
    @(negedge clk);
    if (cyc < LOGN) begin
      log_cnt[cyc] = cnt; log_bo[cyc] = bo; log_busy[cyc] = busy; log_done[cyc] = done;
    end
    check_cycle();
    cyc++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic expect_at(input string nm, input int idx, input int c, input int b,
                           input int bz, input int d);
    if (idx >= LOGN) begin
      n_assert++; n_fail++;
      $display("FAIL %s: log index %0d out of range", nm, idx);
      return;
    end
    chk({nm, "_cnt"}, 32'(log_cnt[idx]), c);
    chk({nm, "_bo"}, 32'(log_bo[idx]), b);
    chk({nm, "_busy"}, 32'(log_busy[idx]), bz);
    chk({nm, "_done"}, 32'(log_done[idx]), d);
  endtask

  initial begin
    int t;
    int lv;
    bit ar;

    // Power-on reset.
    #1 rst = 1'b1;
    t = cyc;
    repeat (2) step(0, 0, 1, 0, 0);
    expect_at("por", t, 0, 0, 0, 0);
    rst = 1'b0;

    // Reset asserted mid-count at cnt=17.
    t = cyc;
    step(1, 0, 1, 0, 20);
    repeat (3) step(0, 0, 1, 0, 0);
    chk("pre_rst_cnt", 32'(cnt), 17);
    #2 rst = 1'b1;
    m_run = 1'b0; m_k = 0; m_done = 1'b0;
    #1;
    chk("rst_async_cnt", 32'(cnt), 0);
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_bo", 32'(bo), 0);
    repeat (2) step(0, 0, 1, 0, 0);
    rst = 1'b0;
    t = cyc;
    repeat (5) step(0, 0, 1, 0, 0);
    expect_at("rst_after0", t, 0, 0, 0, 0);
    expect_at("rst_after4", t + 4, 0, 0, 0, 0);

    // One-shot, N=5.
    t = cyc;
    step(1, 0, 1, 0, 5);
    repeat (9) step(0, 0, 1, 0, 0);
    expect_at("os_c1", t + 1, 5, 0, 1, 0);
    expect_at("os_c5", t + 5, 1, 0, 1, 0);
    expect_at("os_c6", t + 6, 0, 1, 1, 0);
    expect_at("os_c7", t + 7, 0, 0, 0, 1);
    expect_at("os_c8", t + 8, 0, 0, 0, 0);

    // Auto-reload, N=3, enable toggling 1,0.
    t = cyc;
    step(1, 0, 0, 1, 3);
    for (int k = 1; k <= 18; k++) step(0, 0, (k % 2) == 1, 1, 0);
    expect_at("ar_c1", t + 1, 3, 0, 1, 0);
    expect_at("ar_c2", t + 2, 2, 0, 1, 0);
    expect_at("ar_c6", t + 6, 0, 0, 1, 0);
    expect_at("ar_c7", t + 7, 0, 1, 1, 0);
    expect_at("ar_c8", t + 8, 3, 0, 1, 1);
    expect_at("ar_c9", t + 9, 3, 0, 1, 0);
    expect_at("ar_c15", t + 15, 0, 1, 1, 0);
    expect_at("ar_c16", t + 16, 3, 0, 1, 1);
    step(0, 1, 0, 0, 0);

    // Largest start value: 32 enabled cycles to terminal count.
    t = cyc;
    step(1, 0, 1, 0, 31);
    repeat (34) step(0, 0, 1, 0, 0);
    expect_at("max_c1", t + 1, 31, 0, 1, 0);
    expect_at("max_c31", t + 31, 1, 0, 1, 0);
    expect_at("max_c32", t + 32, 0, 1, 1, 0);
    expect_at("max_c33", t + 33, 0, 0, 0, 1);
    expect_at("max_c34", t + 34, 0, 0, 0, 0);

    // N=0 with auto-reload: bo every cycle, done every cycle from cycle 2; then stop.
    t = cyc;
    step(1, 0, 1, 1, 0);
    repeat (5) step(0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    expect_at("n0_c1", t + 1, 0, 1, 1, 0);
    expect_at("n0_c2", t + 2, 0, 1, 1, 1);
    expect_at("n0_c5", t + 5, 0, 1, 1, 1);
    expect_at("n0_c6", t + 6, 0, 1, 1, 1);
    expect_at("n0_c7", t + 7, 0, 0, 0, 0);

    // Stop and load together: stop wins.
    t = cyc;
    step(1, 0, 1, 0, 10);
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 7);
    step(0, 0, 1, 0, 0);
    expect_at("pri_c1", t + 1, 10, 0, 1, 0);
    expect_at("pri_c3", t + 3, 0, 0, 0, 0);

    // Reload at cnt=2 of a 10-count restarts with no done.
    t = cyc;
    step(1, 0, 1, 0, 10);
    repeat (8) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 6);
    repeat (9) step(0, 0, 1, 0, 0);
    expect_at("rl_c9", t + 9, 2, 0, 1, 0);
    expect_at("rl_c10", t + 10, 6, 0, 1, 0);
    expect_at("rl_c11", t + 11, 5, 0, 1, 0);
    expect_at("rl_c16", t + 16, 0, 1, 1, 0);
    expect_at("rl_c17", t + 17, 0, 0, 0, 1);

    // Random traffic checked against the model each cycle.
    ar = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) ar = ~ar;
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
      step($urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0, ar, lv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
